// File: rtl/pwm_ramp_ctrl.sv
// Duty/direction sequencer for one H-bridge PWM channel: slews duty toward a
// loaded goal and routes direction reversals through brake, dead time and re-ramp.
module pwm_ramp_ctrl #(
  parameter int NBITS       = 10,
  parameter int STEP        = 1,
  parameter int RAMP_DIV    = 4800,
  parameter int DEAD_CYCLES = 48000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [NBITS-1:0] target,
  input  logic             target_dir,
  output logic [NBITS-1:0] duty,
  output logic             dir,
  output logic             pwm_en,
  output logic             busy
);

  localparam int CW = $clog2(RAMP_DIV + 1);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [NBITS-1:0] STEP_W = NBITS'(STEP);

  if (NBITS < 1 || STEP < 1 || STEP > (1 << NBITS) - 1 || RAMP_DIV < 1 || DEAD_CYCLES < 1)
  begin : g_param_err
    $error("pwm_ramp_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {S_IDLE, S_RAMP, S_BRAKE, S_DEAD, S_HOLD} state_t;

  state_t           state_q;
  logic [NBITS-1:0] duty_q;
  logic [NBITS-1:0] goal_q;
  logic             dir_q;
  logic             goal_dir_q;
  logic [CW-1:0]    cnt_q;
  logic [DW-1:0]    dcnt_q;

  logic             tick;
  logic [NBITS-1:0] dest;
  logic [NBITS-1:0] duty_d;

  // Move cur toward dst by at most STEP; the clamp to the remaining distance
  // is what prevents both overshoot and wrap at the rails.
  function automatic logic [NBITS-1:0] step_toward(input logic [NBITS-1:0] cur,
                                                   input logic [NBITS-1:0] dst);
    logic [NBITS-1:0] diff;
    if (cur < dst) begin
      diff = dst - cur;
      return cur + ((diff < STEP_W) ? diff : STEP_W);
    end else begin
      diff = cur - dst;
      return cur - ((diff < STEP_W) ? diff : STEP_W);
    end
  endfunction

  assign tick   = (cnt_q == CW'(RAMP_DIV - 1));
  assign dest   = (state_q == S_BRAKE) ? '0 : goal_q;
  assign duty_d = step_toward(duty_q, dest);

  assign duty   = duty_q;
  assign dir    = dir_q;
  assign pwm_en = (state_q == S_RAMP) || (state_q == S_BRAKE) || (state_q == S_HOLD);
  assign busy   = (state_q == S_RAMP) || (state_q == S_BRAKE) || (state_q == S_DEAD) ||
                  (goal_q != duty_q) || (goal_dir_q != dir_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      duty_q     <= '0;
      dir_q      <= 1'b0;
      goal_q     <= '0;
      goal_dir_q <= 1'b0;
      cnt_q      <= '0;
      dcnt_q     <= '0;
    end else if (!en) begin
      // goal_dir follows dir so a later enable does not start a phantom reversal
      state_q    <= S_IDLE;
      duty_q     <= '0;
      goal_q     <= '0;
      goal_dir_q <= dir_q;
      cnt_q      <= '0;
      dcnt_q     <= '0;
    end else begin
      if (load) begin
        goal_q     <= target;
        goal_dir_q <= target_dir;
      end
      case (state_q)
        S_IDLE: begin
          if (goal_dir_q != dir_q) begin
            state_q <= S_DEAD;
            dcnt_q  <= '0;
          end else if (goal_q != '0) begin
            state_q <= S_RAMP;
            cnt_q   <= '0;
          end
        end
        S_RAMP: begin
          if (goal_dir_q != dir_q) begin
            state_q <= S_BRAKE;
            cnt_q   <= '0;
          end else if (duty_q == goal_q) begin
            state_q <= (goal_q == '0) ? S_IDLE : S_HOLD;
          end else if (tick) begin
            duty_q <= duty_d;
            cnt_q  <= '0;
            if (duty_d == goal_q) state_q <= (goal_q == '0) ? S_IDLE : S_HOLD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_BRAKE: begin
          if (duty_q == '0) begin
            state_q <= S_DEAD;
            dcnt_q  <= '0;
          end else if (tick) begin
            duty_q <= duty_d;
            cnt_q  <= '0;
            if (duty_d == '0) begin
              state_q <= S_DEAD;
              dcnt_q  <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DEAD: begin
          // Only place dir changes, so it never toggles while the bridge is driven
          if (dcnt_q == DW'(DEAD_CYCLES - 1)) begin
            dir_q   <= goal_dir_q;
            cnt_q   <= '0;
            state_q <= (goal_q == '0) ? S_IDLE : S_RAMP;
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        S_HOLD: begin
          if ((goal_q != duty_q) || (goal_dir_q != dir_q)) begin
            state_q <= S_RAMP;
            cnt_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl (NBITS=4, STEP=2, RAMP_DIV=3, DEAD_CYCLES=5)
// with a per-cycle expectation queue.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] target;
  logic       target_dir;
  logic [3:0] duty;
  logic       dir;
  logic       pwm_en;
  logic       busy;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.NBITS(4), .STEP(2), .RAMP_DIV(3), .DEAD_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .target(target), .target_dir(target_dir),
    .duty(duty), .dir(dir), .pwm_en(pwm_en), .busy(busy)
  );

  typedef struct {
    logic [3:0] duty;
    logic       dir;
    logic       pwm_en;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk_pop();
    exp_t e;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard: got empty queue, want an entry");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total += 4;
      assert (duty === e.duty) else begin
        bad++; $error("FAIL %s duty: got %0d want %0d", e.tag, duty, e.duty);
      end
      assert (dir === e.dir) else begin
        bad++; $error("FAIL %s dir: got %0b want %0b", e.tag, dir, e.dir);
      end
      assert (pwm_en === e.pwm_en) else begin
        bad++; $error("FAIL %s pwm_en: got %0b want %0b", e.tag, pwm_en, e.pwm_en);
      end
      assert (busy === e.busy) else begin
        bad++; $error("FAIL %s busy: got %0b want %0b", e.tag, busy, e.busy);
      end
    end
  endtask

  // Push the expected outputs after the next edge, clock, then compare.
  task automatic cyc(input logic [3:0] d, input logic di, input logic pe, input logic bz,
                     input string tag);
    exp_t e;
    e.duty = d; e.dir = di; e.pwm_en = pe; e.busy = bz; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    chk_pop();
  endtask

  task automatic cycn(input int n, input logic [3:0] d, input logic di, input logic pe,
                      input logic bz, input string tag);
    for (int i = 0; i < n; i++) cyc(d, di, pe, bz, tag);
  endtask

  // One ramp tick period: two cycles at prev, then the stepped value.
  task automatic rstep(input logic [3:0] prev, input logic [3:0] nxt, input logic di,
                       input logic pe_n, input logic bz_n, input string tag);
    cycn(2, prev, di, 1'b1, 1'b1, tag);
    cyc(nxt, di, pe_n, bz_n, tag);
  endtask

  task automatic do_load(input logic [3:0] t, input logic td);
    load = 1'b1; target = t; target_dir = td;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; target = '0; target_dir = 1'b0;
    cyc(0, 0, 0, 0, "reset");
    rst = 1'b0; en = 1'b1;
    cyc(0, 0, 0, 0, "idle");

    // 1: soft start to 7
    do_load(7, 0);
    cyc(0, 0, 0, 1, "t1_load");
    load = 1'b0;
    cyc(0, 0, 1, 1, "t1_entry");
    rstep(0, 2, 0, 1, 1, "t1_up");
    rstep(2, 4, 0, 1, 1, "t1_up");
    rstep(4, 6, 0, 1, 1, "t1_up");
    rstep(6, 7, 0, 1, 0, "t1_last");
    cycn(2, 7, 0, 1, 0, "t1_hold");

    // 2: soft stop to 0
    do_load(0, 0);
    cyc(7, 0, 1, 1, "t2_load");
    load = 1'b0;
    cyc(7, 0, 1, 1, "t2_entry");
    rstep(7, 5, 0, 1, 1, "t2_dn");
    rstep(5, 3, 0, 1, 1, "t2_dn");
    rstep(3, 1, 0, 1, 1, "t2_dn");
    rstep(1, 0, 0, 0, 0, "t2_idle");
    cycn(2, 0, 0, 0, 0, "t2_idle");

    // 3: reversal from 7/dir0 to 4/dir1
    do_load(7, 0);
    cyc(0, 0, 0, 1, "t3_pre");
    load = 1'b0;
    cyc(0, 0, 1, 1, "t3_pre");
    rstep(0, 2, 0, 1, 1, "t3_pre");
    rstep(2, 4, 0, 1, 1, "t3_pre");
    rstep(4, 6, 0, 1, 1, "t3_pre");
    rstep(6, 7, 0, 1, 0, "t3_pre");
    do_load(4, 1);
    cyc(7, 0, 1, 1, "t3_load");
    load = 1'b0;
    cyc(7, 0, 1, 1, "t3_ramp");
    cyc(7, 0, 1, 1, "t3_brake");
    rstep(7, 5, 0, 1, 1, "t3_brk");
    rstep(5, 3, 0, 1, 1, "t3_brk");
    rstep(3, 1, 0, 1, 1, "t3_brk");
    rstep(1, 0, 0, 0, 1, "t3_dead");
    cycn(4, 0, 0, 0, 1, "t3_dead");
    cyc(0, 1, 1, 1, "t3_flip");
    rstep(0, 2, 1, 1, 1, "t3_up");
    rstep(2, 4, 1, 1, 0, "t3_hold");
    cyc(4, 1, 1, 0, "t3_hold");

    // 4: retarget downward mid-ramp
    do_load(14, 1);
    cyc(4, 1, 1, 1, "t4_load");
    load = 1'b0;
    cyc(4, 1, 1, 1, "t4_entry");
    rstep(4, 6, 1, 1, 1, "t4_up");
    rstep(6, 8, 1, 1, 1, "t4_up");
    do_load(6, 1);
    cyc(8, 1, 1, 1, "t4_reload");
    load = 1'b0;
    cyc(8, 1, 1, 1, "t4_wait");
    cyc(6, 1, 1, 0, "t4_hold");
    cycn(2, 6, 1, 1, 0, "t4_hold");

    // 5: saturation at 15, then enable dropped mid-ramp
    do_load(15, 1);
    cyc(6, 1, 1, 1, "t5_load");
    load = 1'b0;
    cyc(6, 1, 1, 1, "t5_entry");
    rstep(6, 8, 1, 1, 1, "t5_up");
    rstep(8, 10, 1, 1, 1, "t5_up");
    rstep(10, 12, 1, 1, 1, "t5_up");
    rstep(12, 14, 1, 1, 1, "t5_up");
    rstep(14, 15, 1, 1, 0, "t5_sat");
    cycn(2, 15, 1, 1, 0, "t5_sat");
    do_load(3, 1);
    cyc(15, 1, 1, 1, "t5_reload");
    load = 1'b0;
    cyc(15, 1, 1, 1, "t5_entry2");
    rstep(15, 13, 1, 1, 1, "t5_dn");
    cyc(13, 1, 1, 1, "t5_dn");
    en = 1'b0;
    do_load(9, 0);
    cyc(0, 1, 0, 0, "t5_en_off");
    load = 1'b0;
    cyc(0, 1, 0, 0, "t5_en_off");
    en = 1'b1;
    cycn(3, 0, 1, 0, 0, "t5_en_on");

    // 6: reset during DEAD
    do_load(5, 0);
    cyc(0, 1, 0, 1, "t6_load");
    load = 1'b0;
    cycn(3, 0, 1, 0, 1, "t6_dead");
    rst = 1'b1;
    cyc(0, 0, 0, 0, "t6_rst");
    rst = 1'b0;
    cyc(0, 0, 0, 0, "t6_after");
    do_load(0, 0);
    cyc(0, 0, 0, 0, "t6_load0");
    load = 1'b0;
    cycn(3, 0, 0, 0, 0, "t6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
